// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit multi-cycle core.
// Contents: instruction field widths, opcode constants, the halt word,
// 4-bit ALU control codes, the FSM state enum and the opcode-to-ALU
// control decode used by the core.
package mips16_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int REG_W   = 2;
    localparam int IMM_W   = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_NOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_NAND = 4'h5;
    localparam logic [OP_W-1:0] OP_SLT  = 4'h6;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h7;
    localparam logic [OP_W-1:0] OP_LW   = 4'h8;
    localparam logic [OP_W-1:0] OP_SW   = 4'h9;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'hA;
    localparam logic [OP_W-1:0] OP_BNE  = 4'hB;

    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // Address generation (addi/lw/sw) uses ADD; branches compare with SUB.
    function automatic logic [3:0] alu_ctrl_for(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE: alu_ctrl_for = ALU_SUB;
            OP_AND:                 alu_ctrl_for = ALU_AND;
            OP_OR:                  alu_ctrl_for = ALU_OR;
            OP_NOR:                 alu_ctrl_for = ALU_NOR;
            OP_NAND:                alu_ctrl_for = ALU_NAND;
            OP_SLT:                 alu_ctrl_for = ALU_SLT;
            default:                alu_ctrl_for = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips16_alu.sv
// Combinational ALU for the 16-bit core family.
// Ports: ctrl (4-bit ALU code), a/b (DATA_W operands),
//        y (DATA_W result), zero (y == 0, used for beq/bne).
module mips16_alu
    import mips16_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    logic [DATA_W-1:0] diff;

    assign diff = a - b;

    always_comb begin
        y = '0;
        case (ctrl)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = diff;
            // slt is the sign bit of the wrapped subtraction; overflow is ignored.
            ALU_SLT:  y = {{(DATA_W-1){1'b0}}, diff[DATA_W-1]};
            ALU_NOR:  y = ~(a | b);
            ALU_NAND: y = ~(a & b);
            default:  y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/mips16_multicycle_core.sv
// Multi-cycle 16-bit core: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Ports: clock/reset (async, active-high); imem_req/addr/ack/rdata
// instruction port; dmem_req/we/addr/wdata/ack/rdata data port;
// pc, ir, alu_out, halted architectural observation outputs.
// Handshake: a req rises and stays high, with addr/we/wdata stable, up to
// and including the cycle its ack is seen; req drops the cycle after.
// An ack while req is low is ignored.
module mips16_multicycle_core
    import mips16_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int NREGS  = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       ir,
    output logic [DATA_W-1:0] alu_out,
    output logic              halted
);

    state_t            state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] load_data;

    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs, rt, rd, wb_dst;
    logic [DATA_W-1:0] imm_ext, rs_val, rt_val, alu_b, alu_y, wb_val;
    logic [3:0]        alu_ctrl;
    logic              alu_zero, is_imm, taken;
    logic [PC_W-1:0]   pc_seq, br_off;

    assign op      = ir[15:12];
    assign rs      = ir[11:10];
    assign rt      = ir[9:8];
    assign rd      = ir[7:6];
    assign imm_ext = {{(DATA_W-IMM_W){ir[7]}}, ir[7:0]};

    // R0 is never written, but the read is gated as well so it reads 0 by construction.
    assign rs_val = (rs == '0) ? '0 : regs[rs];
    assign rt_val = (rt == '0) ? '0 : regs[rt];

    assign is_imm   = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    assign alu_b    = is_imm ? imm_ext : rt_val;
    assign alu_ctrl = alu_ctrl_for(op);

    mips16_alu #(.DATA_W(DATA_W)) u_alu (
        .ctrl (alu_ctrl),
        .a    (rs_val),
        .b    (alu_b),
        .y    (alu_y),
        .zero (alu_zero)
    );

    assign taken  = ((op == OP_BEQ) && alu_zero) || ((op == OP_BNE) && !alu_zero);
    assign br_off = {{(PC_W-IMM_W-1){ir[7]}}, ir[7:0], 1'b0};
    assign pc_seq = pc + PC_W'(2);

    assign wb_dst = ((op == OP_ADDI) || (op == OP_LW)) ? rt : rd;
    assign wb_val = (op == OP_LW) ? load_data : alu_out;

    assign imem_addr  = pc;
    assign dmem_addr  = alu_out[PC_W-1:0];
    assign dmem_wdata = rt_val;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_FETCH;
            pc        <= '0;
            ir        <= '0;
            alu_out   <= '0;
            halted    <= 1'b0;
            imem_req  <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            load_data <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // First cycle after reset raises req; later fetches arrive with req already high.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (ir == HALT_WORD) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_out <= alu_y;
                    case (op)
                        OP_LW, OP_SW: begin
                            dmem_req <= 1'b1;
                            dmem_we  <= (op == OP_SW);
                            state    <= ST_MEM;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_NAND, OP_SLT, OP_ADDI:
                            state <= ST_WB;
                        OP_BEQ, OP_BNE: begin
                            pc       <= taken ? pc_seq + br_off : pc_seq;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end
                        default: begin
                            pc       <= pc_seq;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_SW) begin
                            pc       <= pc_seq;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end else begin
                            load_data <= dmem_rdata;
                            state     <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (wb_dst != '0) regs[wb_dst] <= wb_val;
                    pc       <= pc_seq;
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips16_multicycle_core.sv
module tb_mips16_multicycle_core;
  localparam int DW = 16;
  localparam int PW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req, imem_ack;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [PW-1:0] dmem_addr, pc;
  logic [DW-1:0] dmem_wdata, dmem_rdata, alu_out;
  logic [15:0]   ir;
  logic          halted;

  always #5 clock = ~clock;

  mips16_multicycle_core #(.DATA_W(DW), .PC_W(PW), .NREGS(4)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .ir(ir), .alu_out(alu_out), .halted(halted)
  );

  int checks = 0;
  int failures = 0;

  // Stimulus memories and the architectural reference model.
  logic [15:0]   prog [int];
  logic [DW-1:0] ram [int];
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_reg [4];
  logic [PW-1:0] m_pc;
  bit            m_halted;
  logic [DW-1:0] m_alu;
  bit            m_alu_valid;
  logic [PW+DW:0] exp_q[$];   // {we, addr, wdata}
  logic [PW+DW:0] e;

  bit mon_en = 0;
  bit dmem_manual = 0;
  int imem_wait_mode = 0, dmem_wait_mode = 0;
  int cyc_cnt, sw_req_cycles;
  bit started;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] prog_word(input logic [PW-1:0] a);
    return prog.exists(int'(a)) ? prog[int'(a)] : 16'hFFFF;
  endfunction

  function automatic logic [DW-1:0] mem_default(input logic [PW-1:0] a);
    return DW'(a) ^ 16'h5A3C;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [PW-1:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : mem_default(a);
  endfunction

  function automatic void m_write_reg(input logic [1:0] d, input logic [DW-1:0] v);
    if (d != 2'd0) m_reg[d] = v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_pc = '0; m_halted = 0; m_alu = '0; m_alu_valid = 0;
    exp_q.delete(); m_mem.delete(); ram.delete();
    cyc_cnt = 0; sw_req_cycles = 0; started = 0;
  endtask

  // Executes one instruction at the architectural level.
  task automatic model_step(input logic [15:0] w);
    logic [3:0] op;
    logic [1:0] rs, rt, rd;
    logic [DW-1:0] a, b, sx, diff;
    logic [PW-1:0] npc, addr;
    op = w[15:12]; rs = w[11:10]; rt = w[9:8]; rd = w[7:6];
    sx = {{(DW-8){w[7]}}, w[7:0]};
    a = m_reg[rs]; b = m_reg[rt];
    npc = m_pc + 16'd2;
    if (w == 16'hFFFF) begin
      m_halted = 1;
      return;
    end
    m_alu_valid = 1;
    case (op)
      4'h0: begin m_alu = a + b; m_write_reg(rd, m_alu); end
      4'h1: begin m_alu = a - b; m_write_reg(rd, m_alu); end
      4'h2: begin m_alu = a & b; m_write_reg(rd, m_alu); end
      4'h3: begin m_alu = a | b; m_write_reg(rd, m_alu); end
      4'h4: begin m_alu = ~(a | b); m_write_reg(rd, m_alu); end
      4'h5: begin m_alu = ~(a & b); m_write_reg(rd, m_alu); end
      4'h6: begin diff = a - b; m_alu = diff[DW-1] ? 1 : 0; m_write_reg(rd, m_alu); end
      4'h7: begin m_alu = a + sx; m_write_reg(rt, m_alu); end
      4'h8: begin
        m_alu = a + sx; addr = m_alu[PW-1:0];
        exp_q.push_back({1'b0, addr, {DW{1'b0}}});
        m_write_reg(rt, m_read(addr));
      end
      4'h9: begin
        m_alu = a + sx; addr = m_alu[PW-1:0];
        exp_q.push_back({1'b1, addr, b});
        m_mem[int'(addr)] = b;
      end
      4'hA: begin m_alu = a - b; if (a == b) npc = npc + {sx[PW-2:0], 1'b0}; end
      4'hB: begin m_alu = a - b; if (a != b) npc = npc + {sx[PW-2:0], 1'b0}; end
      default: m_alu_valid = 0;
    endcase
    m_pc = npc;
  endtask

  task automatic check_arch(input string tag);
    if (m_alu_valid) check({tag, "_alu_out"}, alu_out, m_alu);
    for (int i = 0; i < 4; i++) check($sformatf("%s_R%0d", tag, i), dut.regs[i], m_reg[i]);
  endtask

  // Instruction memory responder: ack after 0..2 wait cycles.
  int i_cnt = 0, i_wait = 0;
  always @(posedge clock or posedge reset) begin
    #2;
    if (reset) begin
      imem_ack = 0; i_cnt = 0;
    end else if (imem_req) begin
      if (i_cnt == 0) i_wait = (imem_wait_mode < 0) ? int'($urandom_range(0, 2)) : imem_wait_mode;
      if (i_cnt >= i_wait) begin
        imem_ack = 1; imem_rdata = prog_word(imem_addr);
      end else begin
        imem_ack = 0; imem_rdata = 16'($urandom);
      end
      i_cnt++;
    end else begin
      imem_ack = 0; i_cnt = 0;
    end
  end

  // Data memory responder.
  int d_cnt = 0, d_wait = 0;
  always @(posedge clock or posedge reset) begin
    #2;
    if (!dmem_manual) begin
      if (reset) begin
        dmem_ack = 0; d_cnt = 0;
      end else if (dmem_req) begin
        if (d_cnt == 0) d_wait = (dmem_wait_mode < 0) ? int'($urandom_range(0, 2)) : dmem_wait_mode;
        if (d_cnt >= d_wait) begin
          dmem_ack = 1;
          if (dmem_we) ram[int'(dmem_addr)] = dmem_wdata;
          else dmem_rdata = ram.exists(int'(dmem_addr)) ? ram[int'(dmem_addr)] : mem_default(dmem_addr);
        end else begin
          dmem_ack = 0; dmem_rdata = DW'($urandom);
        end
        d_cnt++;
      end else begin
        dmem_ack = 0; d_cnt = 0;
      end
    end
  end

  // Compare process, sampling on the falling edge.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (imem_req) started = 1;
      if (started && !halted) cyc_cnt++;
      if (dmem_req && dmem_we) sw_req_cycles++;
      if (imem_req && imem_ack) begin
        check("fetch_addr", imem_addr, m_pc);
        check_arch("retire");
        model_step(prog_word(m_pc));
      end
      if (dmem_req) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dmem_unexpected: got req at addr %0h expected no request", dmem_addr);
        end else begin
          e = exp_q[0];
          check("dmem_we", dmem_we, e[PW+DW]);
          check("dmem_addr", dmem_addr, e[PW+DW-1:DW]);
          if (e[PW+DW]) check("dmem_wdata", dmem_wdata, e[DW-1:0]);
          if (dmem_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_halt(input string name);
    int k;
    k = 0;
    while (!halted && k < 3000) begin @(negedge clock); k++; end
    if (!halted) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got halted=0 expected halted=1", name);
    end
  endtask

  task automatic finish_program(input string name);
    int req_seen;
    wait_halt(name);
    @(negedge clock);
    check({name, "_halted"}, halted, 1);
    check({name, "_pc"}, pc, m_pc);
    check_arch(name);
    check({name, "_dmem_pending"}, exp_q.size(), 0);
    req_seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (imem_req || dmem_req) req_seen++;
    end
    check({name, "_req_after_halt"}, req_seen, 0);
    mon_en = 0;
  endtask

  task automatic start_program(input int iw, input int dw);
    imem_wait_mode = iw; dmem_wait_mode = dw;
    mon_en = 0; reset = 1;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_imem_req", imem_req, 0);
    check("reset_dmem_req", dmem_req, 0);
    check("reset_pc", pc, 0);
    check("reset_halted", halted, 0);
    check("reset_alu_out", alu_out, 0);
    check("reset_ir", ir, 0);
    mon_en = 1;
    reset = 0;
  endtask

  task automatic gen_random(input int n);
    logic [3:0] op4;
    logic [1:0] rs, rt, rd;
    logic [15:0] w;
    int sel;
    prog.delete();
    for (int k = 0; k < n; k++) begin
      sel = $urandom_range(0, 13);
      op4 = 4'(sel);
      rs = 2'($urandom); rt = 2'($urandom); rd = 2'($urandom);
      if (sel <= 6) w = {op4, rs, rt, rd, 6'($urandom)};
      else if (sel <= 9) w = {op4, rs, rt, 8'($urandom)};
      else if (sel <= 11) w = {op4, rs, rt, 8'($urandom_range(0, 3))};
      else if (sel == 12) w = {4'($urandom_range(12, 14)), 12'($urandom)};
      else w = {4'hF, 12'($urandom_range(0, 12'hFFE))};
      prog[2 * k] = w;
    end
  endtask

  initial begin
    int k;
    imem_ack = 0; imem_rdata = '0; dmem_ack = 0; dmem_rdata = '0;

    // ALU program, zero-wait memories.
    prog.delete();
    prog[0] = 16'h710F; prog[2] = 16'h7207; prog[4] = 16'h26C0;
    prog[6] = 16'h16C0; prog[8] = 16'h6940; prog[10] = 16'hFFFF;
    start_program(0, 0);
    finish_program("alu");
    check("alu_lit_R1", dut.regs[1], 16'h0001);
    check("alu_lit_R2", dut.regs[2], 16'h0007);
    check("alu_lit_R3", dut.regs[3], 16'h0008);
    check("alu_lit_pc", pc, 16'd10);
    check("alu_lit_cycles", cyc_cnt, 22);

    // Load/store with two data wait cycles.
    prog.delete();
    prog[0] = 16'h71FE; prog[2] = 16'h9104; prog[4] = 16'h8204; prog[6] = 16'hFFFF;
    start_program(0, 2);
    finish_program("ldst");
    check("ldst_lit_R2", dut.regs[2], 16'hFFFE);
    check("ldst_lit_sw_req_cycles", sw_req_cycles, 3);
    check("ldst_lit_ram4", ram.exists(4) ? ram[4] : 16'h0000, 16'hFFFE);

    // Branches.
    prog.delete();
    prog[0] = 16'h7103; prog[2] = 16'h7203; prog[4] = 16'hC000;
    prog[6] = 16'hA602; prog[8] = 16'h7301; prog[10] = 16'h7301;
    prog[12] = 16'hB605; prog[14] = 16'hA002; prog[16] = 16'h7301;
    prog[18] = 16'hFFFF; prog[20] = 16'hA0FE;
    start_program(-1, 0);
    finish_program("branch");
    check("branch_lit_pc", pc, 16'd18);
    check("branch_lit_R3", dut.regs[3], 16'h0000);

    // Writes to R0 are dropped.
    prog.delete();
    prog[0] = 16'h7105; prog[2] = 16'h0500; prog[4] = 16'h00C0; prog[6] = 16'hFFFF;
    start_program(1, 0);
    finish_program("r0");
    check("r0_lit_alu_out", alu_out, 16'h0000);
    check("r0_lit_R0", dut.regs[0], 16'h0000);
    check("r0_lit_R1", dut.regs[1], 16'h0005);

    // Reset while a store waits for an ack that never comes.
    prog.delete();
    prog[0] = 16'h9008;
    dmem_manual = 1; dmem_ack = 0;
    mon_en = 0; reset = 1; model_reset();
    repeat (2) @(negedge clock);
    reset = 0;
    k = 0;
    while (!dmem_req && k < 50) begin @(negedge clock); k++; end
    check("midmem_req_seen", dmem_req, 1);
    repeat (2) @(negedge clock);
    reset = 1;
    #1;
    check("midmem_dmem_req", dmem_req, 0);
    check("midmem_imem_req", imem_req, 0);
    check("midmem_pc", pc, 0);
    check("midmem_halted", halted, 0);
    for (int i = 0; i < 4; i++) check($sformatf("midmem_R%0d", i), dut.regs[i], 0);
    prog.delete();
    prog[0] = 16'h7109;
    model_reset();
    @(negedge clock);
    mon_en = 1; reset = 0;
    @(posedge clock); #2 dmem_ack = 1; dmem_rdata = 16'hDEAD;
    @(posedge clock); #2 dmem_ack = 0;
    dmem_manual = 0;
    finish_program("midmem");
    check("midmem_lit_pc", pc, 16'd2);
    check("midmem_lit_R1", dut.regs[1], 16'h0009);

    // Randomised programs with random wait states.
    for (int s = 0; s < 6; s++) begin
      gen_random(24);
      start_program(-1, -1);
      finish_program($sformatf("rand%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
